// File: rtl/cjtag_host.sv
// cJTAG OScan1 host: escapes, OAC activation and three-slot SCAN transfers on TCKC/TMSC.
// Define CJTAG_HOST_SCAN_CNT_EN to add the scan_cnt_o completed-scan counter.
module cjtag_host #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic        cmd_tms_i,
    input  logic        cmd_tdi_i,
    output logic        rsp_valid_o,
    output logic        rsp_tdo_o,
    output logic        rsp_err_o,
    output logic        tckc_o,
    output logic        tmsc_o,
    output logic        tmsc_oe_o,
    input  logic        tmsc_i,
`ifdef CJTAG_HOST_SCAN_CNT_EN
    output logic        online_o,
    output logic [15:0] scan_cnt_o
`else
    output logic        online_o
`endif
);

    typedef enum logic [3:0] {
        IDLE, S_NTDI, S_TMS, S_TDO, ESC_RISE, ESC_TOG, ESC_FALL, OAC_SHIFT, ERR_RSP
    } state_t;

    localparam logic [1:0]  OP_SCAN  = 2'b00;
    localparam logic [1:0]  OP_ACT   = 2'b01;
    localparam logic [1:0]  OP_RST   = 2'b10;
    localparam logic [7:0]  DIV_LOAD = 8'(CLK_DIV - 1);
    // {CP, EC, OAC}, shifted out LSB first
    localparam logic [11:0] OAC_WORD = 12'b0000_1000_1100;
    localparam logic [2:0]  TOG_ACT  = 3'd5;
    localparam logic [2:0]  TOG_RST  = 3'd7;

    state_t      state;
    logic [7:0]  div_cnt;
    logic        div_tc;
    logic        phase;
    logic [2:0]  tog_cnt;
    logic [3:0]  slot_cnt;
    logic [10:0] oac_sh;
    logic        tms_q;
    logic        act_q;

    assign div_tc = (div_cnt == 8'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            div_cnt     <= DIV_LOAD;
            phase       <= 1'b0;
            tog_cnt     <= 3'd0;
            slot_cnt    <= 4'd0;
            oac_sh      <= 11'd0;
            tms_q       <= 1'b0;
            act_q       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_tdo_o   <= 1'b0;
            rsp_err_o   <= 1'b0;
            tckc_o      <= 1'b0;
            tmsc_o      <= 1'b1;
            tmsc_oe_o   <= 1'b1;
            online_o    <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    tckc_o      <= 1'b0;
                    tmsc_o      <= 1'b1;
                    tmsc_oe_o   <= 1'b1;
                    div_cnt     <= DIV_LOAD;
                    phase       <= 1'b0;
                    if (cmd_valid_i && cmd_ready_o) begin
                        case (cmd_op_i)
                            OP_SCAN: begin
                                cmd_ready_o <= 1'b0;
                                if (online_o) begin
                                    state  <= S_NTDI;
                                    tmsc_o <= ~cmd_tdi_i;
                                    tms_q  <= cmd_tms_i;
                                end else begin
                                    state <= ERR_RSP;
                                end
                            end
                            OP_ACT, OP_RST: begin
                                cmd_ready_o <= 1'b0;
                                state       <= ESC_RISE;
                                tckc_o      <= 1'b1;
                                act_q       <= (cmd_op_i == OP_ACT);
                            end
                            default: ;
                        endcase
                    end
                end

                // Shared slot engine: low half, rising edge, high half, falling edge advances.
                S_NTDI, S_TMS, S_TDO, OAC_SHIFT: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - 8'd1;
                        if (state == S_TDO && phase && div_cnt == 8'd1)
                            rsp_valid_o <= 1'b1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        phase   <= ~phase;
                        if (!phase) begin
                            tckc_o <= 1'b1;
                            if (state == S_TDO)
                                rsp_tdo_o <= tmsc_i;
                        end else begin
                            tckc_o <= 1'b0;
                            case (state)
                                S_NTDI: begin
                                    state  <= S_TMS;
                                    tmsc_o <= tms_q;
                                end
                                S_TMS: begin
                                    state     <= S_TDO;
                                    tmsc_oe_o <= 1'b0;
                                end
                                S_TDO: begin
                                    state       <= IDLE;
                                    tmsc_o      <= 1'b1;
                                    tmsc_oe_o   <= 1'b1;
                                    cmd_ready_o <= 1'b1;
                                end
                                default: begin
                                    if (slot_cnt == 4'd0) begin
                                        state       <= IDLE;
                                        tmsc_o      <= 1'b1;
                                        online_o    <= 1'b1;
                                        cmd_ready_o <= 1'b1;
                                    end else begin
                                        slot_cnt <= slot_cnt - 4'd1;
                                        tmsc_o   <= oac_sh[0];
                                        oac_sh   <= oac_sh >> 1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                ESC_RISE: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        state   <= ESC_TOG;
                        tmsc_o  <= ~tmsc_o;
                        tog_cnt <= act_q ? TOG_ACT : TOG_RST;
                    end
                end

                ESC_TOG: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (tog_cnt == 3'd0) begin
                            state  <= ESC_FALL;
                            tckc_o <= 1'b0;
                            tmsc_o <= 1'b1;
                            if (!act_q)
                                online_o <= 1'b0;
                        end else begin
                            tmsc_o  <= ~tmsc_o;
                            tog_cnt <= tog_cnt - 3'd1;
                        end
                    end
                end

                ESC_FALL: begin
                    if (!div_tc) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        phase   <= 1'b0;
                        if (act_q) begin
                            state    <= OAC_SHIFT;
                            tmsc_o   <= OAC_WORD[0];
                            oac_sh   <= OAC_WORD[11:1];
                            slot_cnt <= 4'd11;
                        end else begin
                            state       <= IDLE;
                            cmd_ready_o <= 1'b1;
                        end
                    end
                end

                ERR_RSP: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b1;
                    rsp_tdo_o   <= 1'b0;
                    cmd_ready_o <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef CJTAG_HOST_SCAN_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            scan_cnt_o <= 16'd0;
        else if (rsp_valid_o && !rsp_err_o)
            scan_cnt_o <= scan_cnt_o + 16'd1;
    end
`endif

endmodule

// File: doc/cjtag_host.md
CJTAG_HOST -- requirements
Module: cjtag_host

Interface
REQ-001 Parameter CLK_DIV, default 4, clk_i cycles per TCKC half-period; legal range 2..255.
REQ-002 clk_i  in  1  system clock (100 MHz); all logic on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i  in  1  command request.
REQ-005 cmd_ready_o  out  1  block accepts a command this cycle.
REQ-006 cmd_op_i  in  2  command: 00 SCAN, 01 ACTIVATE, 10 RESET_ESC, 11 reserved (treated as NOP).
REQ-007 cmd_tms_i  in  1  TMS value for SCAN.
REQ-008 cmd_tdi_i  in  1  TDI value for SCAN.
REQ-009 rsp_valid_o  out  1  one-cycle pulse, SCAN result available.
REQ-010 rsp_tdo_o  out  1  sampled TDO for the completed SCAN.
REQ-011 rsp_err_o  out  1  qualifies rsp_valid_o: SCAN issued while offline.
REQ-012 tckc_o  out  1  cJTAG clock to bridge tckc_i.
REQ-013 tmsc_o  out  1  cJTAG data driven toward bridge tmsc_i.
REQ-014 tmsc_oe_o  out  1  1 = host drives TMSC, 0 = released for target.
REQ-015 tmsc_i  in  1  TMSC as seen at the pin (target TDO in slot 3).
REQ-016 online_o  out  1  host considers target in OScan1 online state.

Function
REQ-017 Slot = one TCKC period: TCKC low CLK_DIV cycles then high CLK_DIV cycles; tmsc_o/tmsc_oe_o change only on the clk edge that drives TCKC low.
REQ-018 cmd_ready_o SHALL be high only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o; the FSM leaves IDLE on the next cycle.
REQ-019 States: IDLE, S_NTDI, S_TMS, S_TDO, ESC_RISE, ESC_TOG, ESC_FALL, OAC_SHIFT, ERR_RSP.
REQ-020 IDLE: tckc_o=0, tmsc_o=1, tmsc_oe_o=1.
REQ-021 SCAN while online: S_NTDI drives tmsc_o=~cmd_tdi_i, S_TMS drives cmd_tms_i, S_TDO drives tmsc_oe_o=0; total 6*CLK_DIV cycles.
REQ-022 rsp_tdo_o SHALL capture tmsc_i on the clk edge that drives TCKC high in S_TDO; rsp_valid_o pulses on the last cycle of S_TDO, rsp_err_o=0; tmsc_oe_o returns to 1 on that IDLE entry.
REQ-023 SCAN while offline: no TCKC activity; ERR_RSP for one cycle drives rsp_valid_o=1, rsp_err_o=1, rsp_tdo_o=0.
REQ-024 Escape: ESC_RISE raises TCKC with TMSC=1 for CLK_DIV cycles; ESC_TOG inverts tmsc_o every CLK_DIV cycles with TCKC held high, N toggles; ESC_FALL drops TCKC, tmsc_o=1, CLK_DIV cycles.
REQ-025 ACTIVATE: escape with N=6, then OAC_SHIFT emits 12 slots, LSB first, of OAC=4'b1100, EC=4'b1000, CP=4'b0000; online_o sets on the cycle of return to IDLE.
REQ-026 RESET_ESC: escape with N=8; online_o clears on ESC_FALL entry; legal in either online state.
REQ-027 ACTIVATE while already online SHALL re-run the full sequence; online_o stays 1.
REQ-028 NOP completes in one cycle with no output change and no response.
REQ-029 Toggle/slot/divider counters SHALL saturate-free wrap only by explicit reload; no counter exceeds its terminal value.

Reset
REQ-030 On rst_i assertion, immediately: state IDLE, tckc_o=0, tmsc_o=1, tmsc_oe_o=1, online_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_tdo_o=0, cmd_ready_o=0.
REQ-031 cmd_ready_o rises on the first clk edge after rst_i deassertion; reset mid-command discards the command with no response.

Configuration
REQ-032 Macro CJTAG_HOST_SCAN_CNT_EN: when defined, add output scan_cnt_o[15:0], reset 0, incremented on every rsp_valid_o with rsp_err_o=0, wrapping 16'hFFFF->0; when undefined, the port and counter are absent and all other behaviour is identical.

Verification
REQ-033 CLK_DIV=4, ACTIVATE -> 6 TMSC toggles while TCKC high, then 12 TCKC pulses with TMSC 0,0,1,1,0,0,0,1,0,0,0,0; online_o=1; bridge online_o=1.
REQ-034 Online, SCAN tms=1 tdi=0 -> TMSC 1,1, then released; rsp_valid_o 24 cycles after accept; rsp_tdo_o equals bridge tdo.
REQ-035 After reset, 32 SCANs shifting DR after IDCODE instruction -> collected TDO = 32'h1DEAD3FF.
REQ-036 Offline SCAN -> rsp_valid_o next-but-one cycle with rsp_err_o=1, tckc_o stays 0.
REQ-037 Online, RESET_ESC -> 8 toggles, online_o=0, bridge online_o=0.
REQ-038 rst_i asserted mid-S_TDO -> outputs at reset values same cycle, no rsp_valid_o; with CJTAG_HOST_SCAN_CNT_EN, 65536 SCANs -> scan_cnt_o=0.
